// File: rtl/icb_periph_split.sv
// icb_periph_split: routes one ICB master to N_SLV slaves by address decode and keeps responses in command order.
// Optional macro ICB_SPLIT_ERR_SLV_EN routes address misses to an internal error responder.
`ifndef MYRISCV_ADDRDW
`define MYRISCV_ADDRDW 32
`endif
`ifndef MYRISCV_XLEN
`define MYRISCV_XLEN 32
`endif

module icb_periph_split #(
  parameter int N_SLV      = 2,
  parameter int OUTS_DEPTH = 2,
  parameter logic [N_SLV*`MYRISCV_ADDRDW-1:0] SLV_BASE = {32'h0C00_0000, 32'h0200_0000},
  parameter logic [N_SLV*`MYRISCV_ADDRDW-1:0] SLV_MASK = {32'hFC00_0000, 32'hFF00_0000}
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_icb_cmd_valid,
  output logic                              i_icb_cmd_ready,
  input  logic [`MYRISCV_ADDRDW-1:0]        i_icb_cmd_addr,
  input  logic                              i_icb_cmd_read,
  input  logic [`MYRISCV_XLEN-1:0]          i_icb_cmd_wdata,
  input  logic [`MYRISCV_XLEN/8-1:0]        i_icb_cmd_wmask,
  output logic                              i_icb_rsp_valid,
  input  logic                              i_icb_rsp_ready,
  output logic                              i_icb_rsp_err,
  output logic [`MYRISCV_XLEN-1:0]          i_icb_rsp_rdata,
  output logic [N_SLV-1:0]                  o_icb_cmd_valid,
  input  logic [N_SLV-1:0]                  o_icb_cmd_ready,
  output logic [`MYRISCV_ADDRDW-1:0]        o_icb_cmd_addr,
  output logic                              o_icb_cmd_read,
  output logic [`MYRISCV_XLEN-1:0]          o_icb_cmd_wdata,
  output logic [`MYRISCV_XLEN/8-1:0]        o_icb_cmd_wmask,
  input  logic [N_SLV-1:0]                  o_icb_rsp_valid,
  output logic [N_SLV-1:0]                  o_icb_rsp_ready,
  input  logic [N_SLV-1:0]                  o_icb_rsp_err,
  input  logic [N_SLV*`MYRISCV_XLEN-1:0]    o_icb_rsp_rdata
);
  localparam int AW  = `MYRISCV_ADDRDW;
  localparam int DW  = `MYRISCV_XLEN;
  localparam int IDW = $clog2(N_SLV + 1);
  localparam int PW  = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int CW  = $clog2(OUTS_DEPTH + 1);

  logic [N_SLV-1:0] hit;
  logic [IDW-1:0]   sel;
  logic             sel_cmd_ready;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  logic [IDW-1:0]   head;
  logic             rsp_valid_sel, rsp_err_sel;
  logic [DW-1:0]    rsp_rdata_sel;

  logic [IDW-1:0]   id_mem [OUTS_DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    cnt_reg;

  for (genvar gi = 0; gi < N_SLV; gi++) begin : g_hit
    assign hit[gi] = (i_icb_cmd_addr & SLV_MASK[gi*AW +: AW]) ==
                     (SLV_BASE[gi*AW +: AW] & SLV_MASK[gi*AW +: AW]);
  end

  // Lowest-index hit wins; a miss falls through to the default target.
  always_comb begin
`ifdef ICB_SPLIT_ERR_SLV_EN
    sel = IDW'(N_SLV);
`else
    sel = IDW'(N_SLV - 1);
`endif
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (hit[i]) sel = IDW'(i);
    end
  end

  always_comb begin
    o_icb_cmd_valid = '0;
    sel_cmd_ready   = 1'b0;
`ifdef ICB_SPLIT_ERR_SLV_EN
    if (sel == IDW'(N_SLV)) sel_cmd_ready = 1'b1;
`endif
    for (int i = 0; i < N_SLV; i++) begin
      if (sel == IDW'(i)) begin
        o_icb_cmd_valid[i] = i_icb_cmd_valid & ~fifo_full;
        sel_cmd_ready      = o_icb_cmd_ready[i];
      end
    end
  end

  assign i_icb_cmd_ready = sel_cmd_ready & ~fifo_full;
  assign o_icb_cmd_addr  = i_icb_cmd_addr;
  assign o_icb_cmd_read  = i_icb_cmd_read;
  assign o_icb_cmd_wdata = i_icb_cmd_wdata;
  assign o_icb_cmd_wmask = i_icb_cmd_wmask;

  assign fifo_full  = (cnt_reg == CW'(OUTS_DEPTH));
  assign fifo_empty = (cnt_reg == '0);
  assign push       = i_icb_cmd_valid & i_icb_cmd_ready;
  assign pop        = i_icb_rsp_valid & i_icb_rsp_ready;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTS_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Full is judged on the registered count only, so cmd_ready never depends on the response side.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + CW'(1);
        2'b01:   cnt_reg <= cnt_reg - CW'(1);
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr_reg] <= sel;
  end

  assign head = id_mem[rd_ptr_reg];

`ifdef ICB_SPLIT_ERR_SLV_EN
  // Counts error commands accepted before this cycle; the oldest one is always the first to mature.
  logic [CW-1:0] err_cnt_reg;
  logic          err_push, err_pop;
  assign err_push = push & (sel == IDW'(N_SLV));
  assign err_pop  = pop & (head == IDW'(N_SLV));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_reg <= '0;
    end else begin
      case ({err_push, err_pop})
        2'b10:   err_cnt_reg <= err_cnt_reg + CW'(1);
        2'b01:   err_cnt_reg <= err_cnt_reg - CW'(1);
        default: err_cnt_reg <= err_cnt_reg;
      endcase
    end
  end
`endif

  always_comb begin
    rsp_valid_sel = 1'b0;
    rsp_err_sel   = 1'b0;
    rsp_rdata_sel = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (head == IDW'(i)) begin
        rsp_valid_sel = o_icb_rsp_valid[i];
        rsp_err_sel   = o_icb_rsp_err[i];
        rsp_rdata_sel = o_icb_rsp_rdata[i*DW +: DW];
      end
    end
`ifdef ICB_SPLIT_ERR_SLV_EN
    if (head == IDW'(N_SLV)) begin
      rsp_valid_sel = (err_cnt_reg != '0);
      rsp_err_sel   = 1'b1;
      rsp_rdata_sel = '0;
    end
`endif
  end

  assign i_icb_rsp_valid = ~fifo_empty & rsp_valid_sel;
  assign i_icb_rsp_err   = rsp_err_sel;
  assign i_icb_rsp_rdata = rsp_rdata_sel;

  for (genvar gi = 0; gi < N_SLV; gi++) begin : g_rsp_ready
    assign o_icb_rsp_ready[gi] = i_icb_rsp_ready & ~fifo_empty & (head == IDW'(gi));
  end

endmodule

// File: tb/tb_icb_periph_split.sv
// Scoreboard bench for icb_periph_split: two modelled slaves (CLINT-like, PLIC-like) and in-order response checks.
`timescale 1ns/1ps
module tb_icb_periph_split;
  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_icb_cmd_valid;
  logic        i_icb_cmd_ready;
  logic [31:0] i_icb_cmd_addr;
  logic        i_icb_cmd_read;
  logic [31:0] i_icb_cmd_wdata;
  logic [3:0]  i_icb_cmd_wmask;
  logic        i_icb_rsp_valid;
  logic        i_icb_rsp_ready = 1'b0;
  logic        i_icb_rsp_err;
  logic [31:0] i_icb_rsp_rdata;
  logic [N-1:0]    o_icb_cmd_valid;
  logic [N-1:0]    o_icb_cmd_ready;
  logic [31:0]     o_icb_cmd_addr;
  logic            o_icb_cmd_read;
  logic [31:0]     o_icb_cmd_wdata;
  logic [3:0]      o_icb_cmd_wmask;
  logic [N-1:0]    o_icb_rsp_valid;
  logic [N-1:0]    o_icb_rsp_ready;
  logic [N-1:0]    o_icb_rsp_err;
  logic [N*32-1:0] o_icb_rsp_rdata;

  always #5 clk = ~clk;

  icb_periph_split #(.N_SLV(2), .OUTS_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .i_icb_cmd_valid(i_icb_cmd_valid), .i_icb_cmd_ready(i_icb_cmd_ready),
    .i_icb_cmd_addr(i_icb_cmd_addr), .i_icb_cmd_read(i_icb_cmd_read),
    .i_icb_cmd_wdata(i_icb_cmd_wdata), .i_icb_cmd_wmask(i_icb_cmd_wmask),
    .i_icb_rsp_valid(i_icb_rsp_valid), .i_icb_rsp_ready(i_icb_rsp_ready),
    .i_icb_rsp_err(i_icb_rsp_err), .i_icb_rsp_rdata(i_icb_rsp_rdata),
    .o_icb_cmd_valid(o_icb_cmd_valid), .o_icb_cmd_ready(o_icb_cmd_ready),
    .o_icb_cmd_addr(o_icb_cmd_addr), .o_icb_cmd_read(o_icb_cmd_read),
    .o_icb_cmd_wdata(o_icb_cmd_wdata), .o_icb_cmd_wmask(o_icb_cmd_wmask),
    .o_icb_rsp_valid(o_icb_rsp_valid), .o_icb_rsp_ready(o_icb_rsp_ready),
    .o_icb_rsp_err(o_icb_rsp_err), .o_icb_rsp_rdata(o_icb_rsp_rdata)
  );

  typedef struct { logic err; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] data; int due; } slv_rsp_t;

  exp_t exp_q[$];
  int   route_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   rsp_seen = 0;
  logic rand_srdy = 1'b0;
  logic rand_mrdy = 1'b0;
  logic rand_lat  = 1'b0;
  logic mrdy_fixed = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    i_icb_rsp_ready = rand_mrdy ? 1'($urandom_range(0, 1)) : mrdy_fixed;
  end

  function automatic logic [31:0] slv_data(input int s, input logic [31:0] a, input logic rd);
    if (!rd) return 32'h0;
    if (s == 0) return (a == 32'h0200_0000) ? 32'h0000_1234 : (32'hA000_0000 | {8'h0, a[23:0]});
    return 32'hB100_0000 | {8'h0, a[23:0]};
  endfunction

  // Slave 0: fixed 1-cycle latency; slave 1: 3 cycles, or 1..4 when rand_lat is set.
  for (genvar gi = 0; gi < N; gi++) begin : g_slv
    slv_rsp_t    q[$];
    logic        v_reg = 1'b0;
    logic [31:0] d_reg = 32'h0;
    logic        rdy_reg = 1'b1;
    assign o_icb_cmd_ready[gi] = rdy_reg;
    assign o_icb_rsp_valid[gi] = v_reg;
    assign o_icb_rsp_err[gi]   = 1'b0;
    assign o_icb_rsp_rdata[gi*32 +: 32] = d_reg;
    always @(posedge clk) begin
      int lat;
      if (rst) begin
        q.delete();
        v_reg   <= 1'b0;
        rdy_reg <= 1'b1;
      end else begin
        if (o_icb_rsp_valid[gi] && o_icb_rsp_ready[gi]) void'(q.pop_front());
        if (o_icb_cmd_valid[gi] && o_icb_cmd_ready[gi]) begin
          lat = (gi == 0) ? 1 : (rand_lat ? int'($urandom_range(1, 4)) : 3);
          q.push_back('{data: slv_data(gi, o_icb_cmd_addr, o_icb_cmd_read), due: cyc + lat});
        end
        v_reg   <= (q.size() > 0) && (q[0].due <= cyc + 1);
        d_reg   <= (q.size() > 0) ? q[0].data : 32'h0;
        rdy_reg <= rand_srdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin : mon_rsp
    exp_t e;
    if (!rst && i_icb_rsp_valid && i_icb_rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL rsp_unexpected: got err=%0d rdata=0x%h expected none", i_icb_rsp_err, i_icb_rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        rsp_seen++;
        $display("rsp  err=%0d rdata=0x%h", i_icb_rsp_err, i_icb_rsp_rdata);
        chk("rsp_data", {i_icb_rsp_err, i_icb_rsp_rdata}, {e.err, e.data});
      end
    end
  end

  always @(negedge clk) begin : mon_route
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (o_icb_cmd_valid[i] && o_icb_cmd_ready[i]) begin
          if (route_q.size() == 0) begin
            checks++;
            $display("FAIL route_unexpected: got slave %0d expected none", i);
          end else begin
            chk("route", 64'(i), 64'(route_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic rd, input int slv,
                       input logic e, input logic [31:0] d);
    int t = 0;
    i_icb_cmd_valid = 1'b1;
    i_icb_cmd_addr  = a;
    i_icb_cmd_read  = rd;
    i_icb_cmd_wdata = ~a;
    i_icb_cmd_wmask = 4'hF;
    exp_q.push_back('{err: e, data: d});
    if (slv >= 0) route_q.push_back(slv);
    $display("cmd  addr=0x%h read=%0d slave=%0d exp_err=%0d exp_rdata=0x%h", a, rd, slv, e, d);
    forever begin
      @(negedge clk);
      if (i_icb_cmd_ready) break;
      t++;
      if (t > 200) begin
        checks++;
        $display("FAIL cmd_timeout: addr=0x%h never accepted, required acceptance", a);
        break;
      end
    end
    @(posedge clk);
    #1;
    i_icb_cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      t++;
      if (t > 500) begin
        checks++;
        $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
        exp_q.delete();
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_mrdy(input logic v);
    mrdy_fixed = v;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    logic [31:0] a;
    rst = 1'b1;
    i_icb_cmd_valid = 1'b0;
    i_icb_cmd_addr  = 32'h0;
    i_icb_cmd_read  = 1'b0;
    i_icb_cmd_wdata = 32'h0;
    i_icb_cmd_wmask = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", i_icb_rsp_valid, 0);
    chk("reset_cmd_valid", o_icb_cmd_valid, 0);
    chk("reset_slv_rsp_ready", o_icb_rsp_ready, 0);
    chk("reset_cmd_ready", i_icb_cmd_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // CLINT read with 1-cycle slave latency
    fork
      issue(32'h0200_0000, 1'b1, 0, 1'b0, 32'h0000_1234);
      begin @(negedge clk); chk("clint_cmd_valid", o_icb_cmd_valid, 2'b01); end
    join
    @(negedge clk);
    chk("clint_rsp_next_cycle", i_icb_rsp_valid, 1);
    wait_drain();

    // Slow PLIC write then fast CLINT read: CLINT response must wait behind PLIC
    issue(32'h0C00_0004, 1'b0, 1, 1'b0, 32'h0);
    issue(32'h0200_0008, 1'b1, 0, 1'b0, 32'hA000_0008);
    @(negedge clk);
    chk("clint_rsp_stalled", {o_icb_rsp_valid[0], o_icb_rsp_ready[0], i_icb_rsp_valid}, 3'b100);
    wait_drain();

    // FIFO full: third command waits; pop cycle must not also accept it
    set_mrdy(1'b0);
    issue(32'h0200_0010, 1'b1, 0, 1'b0, 32'hA000_0010);
    issue(32'h0C00_0020, 1'b1, 1, 1'b0, 32'hB100_0020);
    fork
      issue(32'h0200_0014, 1'b1, 0, 1'b0, 32'hA000_0014);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("full_stall_cmd_ready", i_icb_cmd_ready, 0);
        end
        mrdy_fixed = 1'b1;
        @(negedge clk);
        chk("pop_cycle_no_push", {i_icb_cmd_ready, i_icb_rsp_valid & i_icb_rsp_ready}, 2'b01);
      end
    join
    wait_drain();

    // Address miss
`ifdef ICB_SPLIT_ERR_SLV_EN
    fork
      issue(32'h4000_0000, 1'b1, -1, 1'b1, 32'h0);
      begin
        @(negedge clk);
        chk("miss_no_cmd_valid", o_icb_cmd_valid, 0);
        chk("miss_cmd_ready", i_icb_cmd_ready, 1);
      end
    join
    @(negedge clk);
    chk("err_rsp_next_cycle", {i_icb_rsp_valid, i_icb_rsp_err}, 2'b11);
`else
    fork
      issue(32'h4000_0000, 1'b1, 1, 1'b0, 32'hB100_0000);
      begin @(negedge clk); chk("miss_default_slave", o_icb_cmd_valid, 2'b10); end
    join
`endif
    wait_drain();

    // Reset with two commands outstanding
    set_mrdy(1'b0);
    issue(32'h0200_0018, 1'b1, 0, 1'b0, 32'hA000_0018);
    issue(32'h0C00_0030, 1'b1, 1, 1'b0, 32'hB100_0030);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    route_q.delete();
    @(negedge clk);
    chk("post_reset_rsp_valid", i_icb_rsp_valid, 0);
    chk("post_reset_slv_rsp_ready", o_icb_rsp_ready, 0);
    set_mrdy(1'b1);
    issue(32'h0200_001C, 1'b1, 0, 1'b0, 32'hA000_001C);
    wait_drain();

    // 16 alternating CLINT/PLIC accesses with random readiness and PLIC latency
    rand_srdy = 1'b1;
    rand_mrdy = 1'b1;
    rand_lat  = 1'b1;
    base = rsp_seen;
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) begin
        a = 32'h0200_0040 + 32'(4 * k);
        issue(a, 1'b1, 0, 1'b0, 32'hA000_0040 + 32'(4 * k));
      end else if (k % 4 == 3) begin
        a = 32'h0C00_0100 + 32'(4 * k);
        issue(a, 1'b0, 1, 1'b0, 32'h0);
      end else begin
        a = 32'h0C00_0100 + 32'(4 * k);
        issue(a, 1'b1, 1, 1'b0, 32'hB100_0100 + 32'(4 * k));
      end
    end
    wait_drain();
    chk("random_rsp_count", 64'(rsp_seen - base), 16);
    rand_srdy = 1'b0;
    rand_mrdy = 1'b0;
    rand_lat  = 1'b0;
    repeat (3) @(posedge clk);
    chk("queues_empty", {32'(exp_q.size()), 32'(route_q.size())}, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/icb_periph_split.md
# icb_periph_split

- Routes one ICB master (core LSU peripheral port) to `N_SLV` ICB slaves (CLINT, PLIC, …) by address decode.
- Sits directly upstream of the CLINT and the other memory-mapped peripherals.
- Tracks outstanding transactions in an ID FIFO so responses return to the master in command order, even when slaves differ in latency.

## Interface
Parameters:
- N_SLV, 2, number of slave ports (1–4)
- OUTS_DEPTH, 2, max outstanding commands (power of 2, ≥1)
- SLV_BASE, {32'h0C00_0000, 32'h0200_0000}, packed N_SLV×`MYRISCV_ADDRDW base addresses, slave 0 in LSBs
- SLV_MASK, {32'hFC00_0000, 32'hFF00_0000}, packed compare masks; slave i hits when (addr & mask_i) == (base_i & mask_i)

Ports (AW = `MYRISCV_ADDRDW, DW = `MYRISCV_XLEN, N = N_SLV):
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- i_icb_cmd_valid  in  1  master command valid
- i_icb_cmd_ready  out  1  master command accepted
- i_icb_cmd_addr  in  AW  address
- i_icb_cmd_read  in  1  1 = read
- i_icb_cmd_wdata  in  DW  write data
- i_icb_cmd_wmask  in  DW/8  byte mask
- i_icb_rsp_valid  out  1  response valid to master
- i_icb_rsp_ready  in  1  master accepts response
- i_icb_rsp_err  out  1  response error
- i_icb_rsp_rdata  out  DW  read data
- o_icb_cmd_valid  out  N  per-slave command valid
- o_icb_cmd_ready  in  N  per-slave command ready
- o_icb_cmd_addr  out  AW  broadcast address
- o_icb_cmd_read  out  1  broadcast read
- o_icb_cmd_wdata  out  DW  broadcast wdata
- o_icb_cmd_wmask  out  DW/8  broadcast wmask
- o_icb_rsp_valid  in  N  per-slave response valid
- o_icb_rsp_ready  out  N  per-slave response ready
- o_icb_rsp_err  in  N  per-slave error
- o_icb_rsp_rdata  in  N×DW  per-slave rdata, packed, slave 0 in LSBs

## Operation
- Decode: combinational `sel` = lowest-index hitting slave. Miss handling is set by the macro (see Configuration).
- Command path:
  - o_icb_cmd_valid[sel] = i_icb_cmd_valid & ~fifo_full.
  - i_icb_cmd_ready = o_icb_cmd_ready[sel] & ~fifo_full.
  - Payload is broadcast to all slaves unregistered.
- ID FIFO:
  - Depth OUTS_DEPTH, entry = slave index (plus error-slot code when the macro is set).
  - Push on master cmd handshake; pop on master rsp handshake.
  - Occupancy counter has width clog2(OUTS_DEPTH+1).
  - Full blocks push even when a pop happens in the same cycle. There is no comb path from rsp to cmd_ready.
  - Simultaneous push and pop when not full: counter is unchanged, head and tail both advance, pointers wrap mod OUTS_DEPTH.
- Response path:
  - head = FIFO head entry.
  - i_icb_rsp_valid = ~fifo_empty & o_icb_rsp_valid[head].
  - o_icb_rsp_ready[i] = i_icb_rsp_ready & ~fifo_empty & (head == i).
  - err and rdata are muxed from head.
  - A response from a non-head slave is stalled (ready=0) until that slave becomes head.
  - A response while the FIFO is empty is ignored and never acknowledged.
- Slave-side burst/beat/lock/excl/size: not produced by this block; tied at top level to 0/0/0/0/2'b10.
- Reset: FIFO empty, counter 0, error slot idle. Reset mid-transaction drops all outstanding IDs; slaves are reset by the same rst.

## Timing
- Zero added latency: cmd and rsp are pure routing. Round-trip latency = slave latency (CLINT: rsp 1 cycle after cmd handshake).
- Reset values: i_icb_rsp_valid=0, o_icb_cmd_valid=0, o_icb_rsp_ready=0 (FIFO empty). i_icb_cmd_ready = o_icb_cmd_ready[sel].
- Throughput: 1 cmd/cycle while not full. With OUTS_DEPTH=1, back-to-back CLINT accesses issue every 2 cycles.
- Valid must not depend on ready on either side. Once asserted, i_icb_rsp_valid holds until the handshake.

## Configuration
- ICB_SPLIT_ERR_SLV_EN defined:
  - Address miss routes to an internal error slave.
  - The error slave always accepts when the FIFO is not full, drives no o_icb_cmd_valid, and pushes code N.
  - It returns rsp_err=1, rdata=0 exactly 1 cycle later (1-entry register, held until the master accepts).
- ICB_SPLIT_ERR_SLV_EN undefined: a miss routes to slave N-1 (default slave), and no error slot exists.

## Test plan
- Read 0x0200_0000 (CLINT mtime_l = 0x1234) with slave ready=1 → o_icb_cmd_valid=2'b01, next cycle i_icb_rsp_valid=1, rdata=0x1234, err=0.
- Issue write to PLIC 0x0C00_0004 (3-cycle latency) then read CLINT 0x0200_0008 (1-cycle latency) → CLINT rsp held (ready=0) until PLIC rsp is accepted; master sees PLIC rsp first, CLINT rsp next cycle.
- OUTS_DEPTH=2, i_icb_rsp_ready=0, three cmds → third cmd stalled (cmd_ready=0) until one rsp is accepted. Pop and third push never occur in the same cycle.
- Macro defined, read 0x4000_0000 → no o_icb_cmd_valid, rsp 1 cycle later with err=1, rdata=0. Macro undefined → o_icb_cmd_valid[1]=1.
- Assert rst with 2 outstanding → next cycle i_icb_rsp_valid=0, FIFO empty, new cmd accepted normally.
- 16 alternating CLINT/PLIC accesses with random ready → responses arrive in issue order, pointers wrap, no loss or duplication.
